// File: rtl/hazard_pkg.sv
// Shared types and opcode constants for the SimpleRISC data-hazard scoreboard.
package hazard_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [3:0] RA_IDX = 4'd15;

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       is_load;
  } sb_entry_t;

  typedef struct packed {
    logic       has_src1;
    logic [3:0] src1;
    logic       has_src2;
    logic [3:0] src2;
    logic       writes;
    logic [3:0] dest;
    logic       is_load;
  } dec_t;

endpackage

// File: rtl/insn_decode.sv
// Extracts register read/write usage of one SimpleRISC instruction word.
module insn_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [4:0] op;
  logic       imm;
  logic [3:0] rd, rs1, rs2;
  logic       unused_bits;

  assign op          = ir_i[31:27];
  assign imm         = ir_i[26];
  assign rd          = ir_i[25:22];
  assign rs1         = ir_i[21:18];
  assign rs2         = ir_i[17:14];
  assign unused_bits = ^ir_i[13:0];

  always_comb begin
    dec_o.has_src1 = 1'b1;
    dec_o.src1     = rs1;
    dec_o.has_src2 = ~imm;
    dec_o.src2     = rs2;
    dec_o.writes   = 1'b1;
    dec_o.dest     = rd;
    dec_o.is_load  = (op == OP_LD);
    case (op)
      OP_NOP, OP_B, OP_BEQ, OP_BGT: begin
        dec_o.has_src1 = 1'b0;
        dec_o.has_src2 = 1'b0;
        dec_o.writes   = 1'b0;
      end
      OP_CALL: begin
        dec_o.has_src1 = 1'b0;
        dec_o.has_src2 = 1'b0;
        dec_o.dest     = RA_IDX;
      end
      OP_RET: begin
        dec_o.src1     = RA_IDX;
        dec_o.has_src2 = 1'b0;
        dec_o.writes   = 1'b0;
      end
      OP_NOT, OP_MOV: dec_o.has_src1 = 1'b0;
      // store data comes from rd, independent of the immediate bit
      OP_ST: begin
        dec_o.has_src2 = 1'b1;
        dec_o.src2     = rd;
        dec_o.writes   = 1'b0;
      end
      OP_CMP: dec_o.writes = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard beside OF: stall decision, per-operand
// forward select, EX-hold/flush handling and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b1,
  parameter int SEL_W  = $clog2(DEPTH+1),
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             of_valid,
  input  logic [31:0]      of_ir,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic [SEL_W-1:0] inflight,
  output logic [CNT_W-1:0] stall_cnt
);

  dec_t                  dec;
  sb_entry_t [DEPTH:1]   sb_q, sb_d;
  sb_entry_t             new_ent;
  logic [DEPTH:1]        m1, m2;
  logic [SEL_W-1:0]      pri_a, pri_b, cnt_v;
  logic                  gate, hz, hazard_stall, issue;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  insn_decode u_dec (.ir_i(of_ir), .dec_o(dec));

  for (genvar k = 1; k <= DEPTH; k++) begin : g_match
    assign m1[k] = sb_q[k].valid & dec.has_src1 & (dec.src1 == sb_q[k].dest);
    assign m2[k] = sb_q[k].valid & dec.has_src2 & (dec.src2 == sb_q[k].dest);
  end

  // Walk from the oldest stage down so the youngest match wins.
  always_comb begin
    pri_a = '0;
    pri_b = '0;
    cnt_v = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (m1[k]) pri_a = SEL_W'(k);
      if (m2[k]) pri_b = SEL_W'(k);
    end
    for (int k = 1; k <= DEPTH; k++) cnt_v = cnt_v + SEL_W'(sb_q[k].valid);
  end

  assign gate         = of_valid & ~flush;
  assign hz           = FWD_EN ? (sb_q[1].is_load & (m1[1] | m2[1])) : |(m1 | m2);
  assign hazard_stall = gate & hz;
  assign stall        = hazard_stall | ex_hold;
  assign fwd_sel_a    = (FWD_EN && gate && !hazard_stall) ? pri_a : '0;
  assign fwd_sel_b    = (FWD_EN && gate && !hazard_stall) ? pri_b : '0;
  assign inflight     = cnt_v;
  assign stall_cnt    = stall_cnt_q;

  assign issue           = of_valid & ~stall & ~flush;
  assign new_ent.valid   = issue & dec.writes;
  assign new_ent.dest    = new_ent.valid ? dec.dest : '0;
  assign new_ent.is_load = new_ent.valid & dec.is_load;

  // Under ex_hold EX keeps its instruction, a bubble enters MA and older drain.
  assign sb_d[1] = ex_hold ? sb_q[1] : new_ent;
  for (genvar k = 2; k <= DEPTH; k++) begin : g_shift
    if (k == 2) begin : g_s2
      assign sb_d[k] = ex_hold ? sb_entry_t'('0) : sb_q[k-1];
    end else begin : g_sn
      assign sb_d[k] = sb_q[k-1];
    end
  end

  assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
